// File: rtl/cipher_pkg.sv
// Shared definitions for the keypad cipher sequencer: state encoding,
// default datapath widths and the slot-count helper.
package cipher_pkg;

    localparam int CIPHER_ADDR_W = 2;
    localparam int CIPHER_DATA_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WORD = 3'd1,
        ST_KEY  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic int slot_count(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/entry_slot_counter.sv
// Write-address counter for one SRAM: advances on each accepted entry,
// wraps after the last slot and latches a sticky full flag until cleared.
module entry_slot_counter #(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] count,
    output logic              wrap,
    output logic              full
);

    assign wrap = inc && !full && (count == '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            full  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            full  <= 1'b0;
        end else if (inc && !full) begin
            count <= count + 1'b1;
            if (wrap) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cipher_seq_ctrl.sv
// Keypad cipher sequencer: steers digit writes into the word/key SRAMs and
// sweeps the shared read address. Optional macro: CIPHER_CLEAR_ON_ENTRY_EN.
module cipher_seq_ctrl
    import cipher_pkg::*;
#(
    parameter int ADDR_W = CIPHER_ADDR_W,
    parameter int DATA_W = CIPHER_DATA_W,
    parameter int DWELL  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] digit,
    input  logic              digit_vld,
    input  logic              star,
    input  logic              sharp,
    output logic              word_we,
    output logic              key_we,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_vld,
    output logic              word_full,
    output logic              key_full,
    output logic              done,
    output logic [2:0]        state
);

    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(slot_count(ADDR_W) - 1);

    state_t              cur_state;
    state_t              nxt_state;
    logic                ev_star;
    logic                ev_sharp;
    logic                ev_digit;
    logic                word_inc;
    logic                key_inc;
    logic                word_clr;
    logic                key_clr;
    logic [ADDR_W-1:0]   word_cnt;
    logic [ADDR_W-1:0]   key_cnt;
    logic                word_wrap;
    logic                key_wrap;
    logic                unused_wrap;
    logic [DW_W-1:0]     dwell_cnt;

    // The sticky full flags already capture the wrap events we care about.
    assign unused_wrap = word_wrap | key_wrap;

`ifdef CIPHER_CLEAR_ON_ENTRY_EN
    logic              clr_busy;
    logic [ADDR_W-1:0] clr_addr;
    logic              pend_star;
    logic              pend_sharp;
    logic              entering;

    // Keys pressed during the zero sweep are held and replayed once it ends.
    assign ev_star  = !clr_busy && (star || pend_star);
    assign ev_sharp = !clr_busy && (sharp || pend_sharp) && !(star || pend_star);
    assign ev_digit = !clr_busy && digit_vld && !star && !sharp;
    assign entering = (cur_state == ST_IDLE) &&
                      ((nxt_state == ST_WORD) || (nxt_state == ST_KEY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_busy   <= 1'b0;
            clr_addr   <= '0;
            pend_star  <= 1'b0;
            pend_sharp <= 1'b0;
        end else begin
            if (entering) begin
                clr_busy <= 1'b1;
                clr_addr <= '0;
            end else if (clr_busy) begin
                clr_addr <= clr_addr + 1'b1;
                if (clr_addr == ADDR_LAST) begin
                    clr_busy <= 1'b0;
                end
            end
            if (clr_busy) begin
                if (star) begin
                    pend_star <= 1'b1;
                end else if (sharp) begin
                    pend_sharp <= 1'b1;
                end
            end else begin
                pend_star  <= 1'b0;
                pend_sharp <= 1'b0;
            end
        end
    end
`else
    assign ev_star  = star;
    assign ev_sharp = sharp && !star;
    assign ev_digit = digit_vld && !star && !sharp;
`endif

    assign word_inc = (cur_state == ST_WORD) && ev_digit && !word_full;
    assign key_inc  = (cur_state == ST_KEY)  && ev_digit && !key_full;

    entry_slot_counter #(.ADDR_W(ADDR_W)) u_word_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (word_inc),
        .clr   (word_clr),
        .count (word_cnt),
        .wrap  (word_wrap),
        .full  (word_full)
    );

    entry_slot_counter #(.ADDR_W(ADDR_W)) u_key_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (key_inc),
        .clr   (key_clr),
        .count (key_cnt),
        .wrap  (key_wrap),
        .full  (key_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        word_clr  = 1'b0;
        key_clr   = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (ev_star) begin
                    nxt_state = ST_WORD;
                end else if (ev_sharp) begin
                    nxt_state = ST_KEY;
                end
            end
            ST_WORD: begin
                if (ev_star) begin
                    nxt_state = ST_IDLE;
                end else if (ev_sharp) begin
                    nxt_state = ST_KEY;
                end
            end
            ST_KEY: begin
                if (ev_star) begin
                    nxt_state = ST_WORD;
                end else if (ev_sharp) begin
                    nxt_state = (word_full && key_full) ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ev_star || ev_sharp) begin
                    nxt_state = ST_IDLE;
                end else if ((rd_addr == ADDR_LAST) && (dwell_cnt == DWELL_LAST)) begin
                    nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ev_star || ev_sharp) begin
                    nxt_state = ST_IDLE;
                    word_clr  = 1'b1;
                    key_clr   = 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
`ifdef CIPHER_CLEAR_ON_ENTRY_EN
        if ((cur_state == ST_IDLE) && (nxt_state == ST_WORD)) begin
            word_clr = 1'b1;
        end
        if ((cur_state == ST_IDLE) && (nxt_state == ST_KEY)) begin
            key_clr = 1'b1;
        end
`endif
    end

    // Strobes are registered so each write lands exactly one cycle after its digit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_we <= 1'b0;
            key_we  <= 1'b0;
            wr_data <= '0;
            wr_addr <= '0;
        end else begin
            word_we <= word_inc;
            key_we  <= key_inc;
            if (word_inc) begin
                wr_data <= digit;
                wr_addr <= word_cnt;
            end else if (key_inc) begin
                wr_data <= digit;
                wr_addr <= key_cnt;
            end
`ifdef CIPHER_CLEAR_ON_ENTRY_EN
            if (clr_busy) begin
                word_we <= (cur_state == ST_WORD);
                key_we  <= (cur_state == ST_KEY);
                wr_data <= '0;
                wr_addr <= clr_addr;
            end
`endif
        end
    end

    // The read address only moves while RUN continues; any exit parks it at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr   <= '0;
            dwell_cnt <= '0;
        end else if ((cur_state == ST_RUN) && (nxt_state == ST_RUN)) begin
            if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                rd_addr   <= rd_addr + 1'b1;
            end else begin
                dwell_cnt <= dwell_cnt + 1'b1;
            end
        end else begin
            rd_addr   <= '0;
            dwell_cnt <= '0;
        end
    end

    assign rd_vld = (cur_state == ST_RUN);
    assign done   = (cur_state == ST_DONE);
    assign state  = cur_state;

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Scoreboard bench for cipher_seq_ctrl: a cycle-level reference model pushes
// expected per-cycle outputs and SRAM writes; a negedge monitor pops and compares.
module tb_cipher_seq_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int DWELL  = 8;
    localparam int SLOTS  = 1 << ADDR_W;

    localparam int M_IDLE = 0;
    localparam int M_WORD = 1;
    localparam int M_KEY  = 2;
    localparam int M_RUN  = 3;
    localparam int M_DONE = 4;

    typedef struct {
        int st;
        bit wf;
        bit kf;
        bit rv;
        int ra;
        bit dn;
    } exp_cyc_t;

    typedef struct {
        bit is_key;
        int addr;
        int data;
        int due;
    } exp_wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] digit = '0;
    logic              digit_vld = 1'b0;
    logic              star = 1'b0;
    logic              sharp = 1'b0;
    logic              word_we;
    logic              key_we;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_vld;
    logic              word_full;
    logic              key_full;
    logic              done;
    logic [2:0]        state;

    int       n_tests = 0;
    int       n_fail  = 0;
    int       cyc     = 0;
    bit       mon_en  = 0;
    int       m_state = M_IDLE;
    int       wn      = 0;
    int       kn      = 0;
    int       run_t   = 0;
    exp_cyc_t cyc_q[$];
    exp_wr_t  wq[$];
    exp_cyc_t mr;
    exp_wr_t  mw;

    cipher_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .digit     (digit),
        .digit_vld (digit_vld),
        .star      (star),
        .sharp     (sharp),
        .word_we   (word_we),
        .key_we    (key_we),
        .wr_data   (wr_data),
        .wr_addr   (wr_addr),
        .rd_addr   (rd_addr),
        .rd_vld    (rd_vld),
        .word_full (word_full),
        .key_full  (key_full),
        .done      (done),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_word_we"}, 32'(word_we), 0);
        checkOutput({tag, "_key_we"}, 32'(key_we), 0);
        checkOutput({tag, "_wr_data"}, 32'(wr_data), 0);
        checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 0);
        checkOutput({tag, "_rd_vld"}, 32'(rd_vld), 0);
        checkOutput({tag, "_word_full"}, 32'(word_full), 0);
        checkOutput({tag, "_key_full"}, 32'(key_full), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
    endtask

    task automatic modelReset();
        m_state = M_IDLE;
        wn      = 0;
        kn      = 0;
        run_t   = 0;
        wq.delete();
        cyc_q.delete();
    endtask

    // Reference rules, one keypad cycle at a time.
    task automatic modelStep(input bit s, input bit h, input bit dv, input int d);
        bit ks, kh, kd;
        exp_wr_t w;
        ks = s;
        kh = h && !s;
        kd = dv && !s && !h;
        case (m_state)
            M_IDLE: begin
                if (ks) m_state = M_WORD;
                else if (kh) m_state = M_KEY;
            end
            M_WORD: begin
                if (kd && wn < SLOTS) begin
                    w = '{0, wn, d, cyc + 1};
                    wq.push_back(w);
                    wn++;
                end
                if (ks) m_state = M_IDLE;
                else if (kh) m_state = M_KEY;
            end
            M_KEY: begin
                if (kd && kn < SLOTS) begin
                    w = '{1, kn, d, cyc + 1};
                    wq.push_back(w);
                    kn++;
                end
                if (ks) m_state = M_WORD;
                else if (kh) begin
                    if (wn == SLOTS && kn == SLOTS) begin
                        m_state = M_RUN;
                        run_t   = 0;
                    end else begin
                        m_state = M_IDLE;
                    end
                end
            end
            M_RUN: begin
                if (ks || kh) m_state = M_IDLE;
                else begin
                    run_t++;
                    if (run_t == DWELL * SLOTS) m_state = M_DONE;
                end
            end
            default: begin
                if (ks || kh) begin
                    m_state = M_IDLE;
                    wn = 0;
                    kn = 0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit s, input bit h, input bit dv, input int d);
        exp_cyc_t r;
        star      = s;
        sharp     = h;
        digit_vld = dv;
        digit     = DATA_W'(d);
        cyc++;
        r.st = m_state;
        r.wf = (wn == SLOTS);
        r.kf = (kn == SLOTS);
        r.rv = (m_state == M_RUN);
        r.ra = (m_state == M_RUN) ? run_t / DWELL : 0;
        r.dn = (m_state == M_DONE);
        cyc_q.push_back(r);
        modelStep(s, h, dv, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0);
    endtask

    task automatic enterDigits(input int a, input int b, input int c, input int e);
        int v[4];
        v = '{a, b, c, e};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, v[i]);
            applyStimulus(0, 0, 0, 0);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc_q.size() > 0) begin
                mr = cyc_q.pop_front();
                checkOutput("state", 32'(state), mr.st);
                checkOutput("word_full", 32'(word_full), 32'(mr.wf));
                checkOutput("key_full", 32'(key_full), 32'(mr.kf));
                checkOutput("rd_vld", 32'(rd_vld), 32'(mr.rv));
                checkOutput("rd_addr", 32'(rd_addr), mr.ra);
                checkOutput("done", 32'(done), 32'(mr.dn));
            end
            checkOutput("strobe_overlap", 32'(word_we & key_we), 0);
            if (word_we || key_we) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected_write", 32'(word_we | key_we), 0);
                end else begin
                    mw = wq.pop_front();
                    checkOutput("wr_target_key", 32'(key_we), 32'(mw.is_key));
                    checkOutput("wr_addr", 32'(wr_addr), mw.addr);
                    checkOutput("wr_data", 32'(wr_data), mw.data);
                    checkOutput("wr_cycle", cyc, mw.due);
                end
            end
        end
    end

    initial begin
        int r;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        #1 rst = 1'b1;
        modelReset();
        mon_en = 1;

        // Word load 3,1,4,1 then an overflow digit that must not write.
        applyStimulus(1, 0, 0, 0);
        enterDigits(3, 1, 4, 1);
        applyStimulus(0, 0, 1, 9);
        idle(2);

        // Key load 2,7,1,8 then sharp into RUN; reset asynchronously at rd_addr 2.
        applyStimulus(0, 1, 0, 0);
        enterDigits(2, 7, 1, 8);
        applyStimulus(0, 1, 0, 0);
        idle(2 * DWELL);
        checkOutput("pre_reset_rd_addr", 32'(rd_addr), 2);
        checkOutput("pending_writes_before_reset", wq.size(), 0);
        mon_en = 0;
        #1 rst = 1'b0;
        #1 checkResetOutputs("async_reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        modelReset();
        mon_en = 1;

        // Word only, then sharp, sharp: KEY then back to IDLE, never RUN.
        applyStimulus(1, 0, 0, 0);
        enterDigits(5, 6, 7, 8);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0);
        idle(3);

        // Star and sharp together go to WORD; digit with star is dropped.
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 0, 1, 4);
        idle(2);

        // Complete sweep to DONE, then clear and reload.
        applyStimulus(0, 1, 0, 0);
        enterDigits($urandom_range(0, 15), $urandom_range(0, 15),
                    $urandom_range(0, 15), $urandom_range(0, 15));
        applyStimulus(0, 1, 0, 0);
        idle(DWELL * SLOTS + 4);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        enterDigits(1, 2, 3, 4);

        // Randomised keypad traffic, including key/digit collisions.
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            applyStimulus(r < 3 || r == 6, (r >= 3 && r < 7), $urandom_range(0, 99) < 40,
                          $urandom_range(0, 15));
        end
        idle(3);

        checkOutput("write_queue_drained", wq.size(), 0);
        checkOutput("cycle_queue_drained", cyc_q.size(), 0);
        mon_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
